// File: rtl/glyph_fetch_arbiter_pkg.sv
// glyph_fetch_arbiter_pkg: shared display constants for the glyph fetch path.
package glyph_fetch_arbiter_pkg;
  localparam int GLYPH_ROWS = 6;
  localparam int GLYPH_COLS = 6;
  localparam int GLYPH_SLOT = 8;
  localparam logic [7:0] CHAR_FIRST = 8'h20;
  localparam logic [7:0] CHAR_LAST = 8'h5F;
  function automatic logic glyph_in_range(input logic [7:0] ch, input logic [2:0] row);
    return ch >= CHAR_FIRST && ch <= CHAR_LAST && row < 3'(GLYPH_ROWS);
  endfunction
endpackage

// File: rtl/glyph_fetch_arbiter_rr_pick.sv
// rr_pick: rotate-priority-encode; search starts at ptr+1 (mod N).
module rr_pick #(
  parameter int N = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);
  // Walk from farthest to nearest so the nearest active requester wins last.
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int k = N; k >= 1; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        gnt = '0;
        gnt[(int'(ptr) + k) % N] = 1'b1;
        idx = IW'((int'(ptr) + k) % N);
      end
    end
  end
endmodule

// File: rtl/glyph_fetch_arbiter.sv
// glyph_fetch_arbiter: round-robin font ROM arbiter with one-cycle response.
// Define GLYPH_ARB_FIXED_PRI_EN for lowest-index fixed priority instead.
module glyph_fetch_arbiter
  import glyph_fetch_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ROM_AW = 9
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ*8-1:0]    req_char,
  input  logic [NUM_REQ*3-1:0]    req_row,
  output logic [NUM_REQ-1:0]      gnt,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic [GLYPH_COLS-1:0]   rsp_bits,
  output logic                    rom_en,
  output logic [ROM_AW-1:0]       rom_addr,
  input  logic [GLYPH_COLS-1:0]   rom_data
);
  localparam int IW = $clog2(NUM_REQ);
  logic [IW-1:0] ptr, idx;
  logic [7:0] ch, off;
  logic [2:0] row;
  logic hit, blank;
  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (.req(req), .ptr(ptr), .gnt(gnt), .idx(idx));
  always_comb begin
    ch = req_char[int'(idx)*8 +: 8];
    row = req_row[int'(idx)*3 +: 3];
    off = ch - CHAR_FIRST;
    hit = |req && glyph_in_range(ch, row);
    rom_en = hit;
    rom_addr = hit ? ROM_AW'(int'(off) * GLYPH_SLOT + int'(row)) : '0;
    rsp_bits = (|rsp_valid && !blank) ? rom_data : '0;
  end
`ifdef GLYPH_ARB_FIXED_PRI_EN
  // A pointer pinned at the top index makes the search start at 0.
  assign ptr = IW'(NUM_REQ - 1);
`else
  always_ff @(posedge clk or posedge reset)
    if (reset) ptr <= IW'(NUM_REQ - 1);
    else if (|req) ptr <= idx;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rsp_valid <= '0;
      blank <= 1'b0;
    end else begin
      rsp_valid <= gnt;
      blank <= !hit;
    end
endmodule
